// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad column scanner.
// Optional build macro: KEYPAD_MULTI_ROW_REJECT_EN (see keypad_col_scanner.sv).
package keypad_pkg;

    typedef enum logic [1:0] {
        SETTLE,
        SAMPLE,
        LOCK
    } scan_state_t;

    localparam logic [3:0] COLS_RESET = 4'b0001;

    // Hex value of each key, indexed {row, col}
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [1:0] lowest_row(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [1:0] col_index(input logic [3:0] c);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic multi_bit(input logic [3:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

endpackage

// File: rtl/keypad_col_scanner_if.sv
// Keypad-side and debouncer-side signals of the column scanner.
// Optional build macro: none.
interface keypad_col_scanner_if;

    logic [3:0] rows;
    logic       hold;
    logic [3:0] cols;
    logic [3:0] q_row_keys;
    logic [3:0] hex_code;
    logic       key_valid;

    modport master (
        input  rows,
        input  hold,
        output cols,
        output q_row_keys,
        output hex_code,
        output key_valid
    );

    modport slave (
        output rows,
        output hold,
        input  cols,
        input  q_row_keys,
        input  hex_code,
        input  key_valid
    );

endinterface

// File: rtl/keypad_col_scanner_sync_2ff.sv
// Parameterized-width two-flop synchronizer for asynchronous inputs.
// Optional build macro: none.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_col_scanner.sv
// Keypad column scanner: walks a one-hot column drive and locks on a pressed key.
// Optional build macro: KEYPAD_MULTI_ROW_REJECT_EN treats multi-row samples as no key.
module keypad_col_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES = 100
) (
    input logic                  clk,
    input logic                  reset,
    keypad_col_scanner_if.master kp
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    scan_state_t      state;
    logic [CNT_W-1:0] counter;
    logic [3:0]       row_sync;
    logic [3:0]       cols_q;
    logic [3:0]       q_row_q;
    logic [3:0]       hex_q;
    logic             valid_q;
    logic             row_hit;

    sync_2ff #(.WIDTH(4)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (kp.rows),
        .q     (row_sync)
    );

    // Decides whether a sampled row vector counts as a key press
    always_comb begin
        row_hit = 1'b0;
`ifdef KEYPAD_MULTI_ROW_REJECT_EN
        row_hit = (row_sync != 4'd0) && !multi_bit(row_sync);
`else
        row_hit = (row_sync != 4'd0);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= SETTLE;
            counter <= '0;
            cols_q  <= COLS_RESET;
            q_row_q <= 4'd0;
            hex_q   <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                SETTLE: begin
                    if (counter == CNT_LAST) begin
                        counter <= '0;
                        state   <= SAMPLE;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                SAMPLE: begin
                    q_row_q <= row_sync;
                    if (row_hit) begin
                        hex_q   <= KEY_MAP[{lowest_row(row_sync), col_index(cols_q)}];
                        valid_q <= 1'b1;
                        state   <= LOCK;
                    end else begin
                        cols_q <= {cols_q[2:0], cols_q[3]};
                        state  <= SETTLE;
                    end
                end
                LOCK: begin
                    // hold keeps the column even once the rows have gone quiet
                    if (row_sync == 4'd0 && !kp.hold) begin
                        valid_q <= 1'b0;
                        q_row_q <= 4'd0;
                        cols_q  <= {cols_q[2:0], cols_q[3]};
                        state   <= SETTLE;
                    end else begin
                        q_row_q <= row_sync;
                    end
                end
                default: begin
                    state <= SETTLE;
                end
            endcase
        end
    end

    assign kp.cols       = cols_q;
    assign kp.q_row_keys = q_row_q;
    assign kp.hex_code   = hex_q;
    assign kp.key_valid  = valid_q;

endmodule

// File: tb/tb_keypad_col_scanner.sv
// Randomized bench for keypad_col_scanner against a key-matrix reference model.
// Optional build macro: KEYPAD_MULTI_ROW_REJECT_EN changes the multi-key expectations.
module tb_keypad_col_scanner;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pressed;
    logic        hold_in;
    bit          check_en;
    int          check_count;
    int          fail_count;

    keypad_col_scanner_if kif ();

    keypad_col_scanner #(.SETTLE_CYCLES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kif)
    );

    always #5 clk = ~clk;

    // Physical key matrix: a pressed key shorts its row to its column's drive
    always_comb begin
        kif.rows = 4'd0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && kif.cols[c]) kif.rows[r] = 1'b1;
            end
        end
    end
    assign kif.hold = hold_in;

    string      keys = "123A456B789CE0FD";
    int         m_col;
    int         m_phase;
    bit         m_locked;
    logic [3:0] m_q;
    logic [3:0] m_hex;
    logic       m_valid;
    logic [3:0] m_pipe0;
    logic [3:0] m_pipe1;
    logic [3:0] m_rs;

    function automatic logic [3:0] key_value(input int idx);
        byte ch;
        ch = keys[idx];
        if (ch >= 48 && ch <= 57) return 4'(ch - 48);
        return 4'(ch - 65 + 10);
    endfunction

    function automatic int lowest_set(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic bit key_ok(input logic [3:0] v);
`ifdef KEYPAD_MULTI_ROW_REJECT_EN
        return $countones(v) == 1;
`else
        return $countones(v) >= 1;
`endif
    endfunction

    task automatic model_reset();
        m_col = 0; m_phase = 0; m_locked = 0;
        m_q = 4'd0; m_hex = 4'd0; m_valid = 1'b0;
        m_pipe0 = 4'd0; m_pipe1 = 4'd0;
    endtask

    always @(negedge reset) model_reset();

    // Each column: S settle cycles, then one sample cycle
    always @(posedge clk) begin
        if (reset) begin
            m_rs = m_pipe1;
            m_pipe1 = m_pipe0;
            m_pipe0 = kif.rows;
            if (m_locked) begin
                if (m_rs == 4'd0 && !hold_in) begin
                    m_locked = 0; m_valid = 1'b0; m_q = 4'd0;
                    m_col = (m_col + 1) % 4; m_phase = 0;
                end else begin
                    m_q = m_rs;
                end
            end else if (m_phase < S) begin
                m_phase++;
            end else begin
                m_q = m_rs;
                m_phase = 0;
                if (key_ok(m_rs)) begin
                    m_locked = 1; m_valid = 1'b1;
                    m_hex = key_value(lowest_set(m_rs) * 4 + m_col);
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end
        end
    end

    task automatic check_output(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        check_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (check_en) begin
            check_output("cols", kif.cols, 4'(4'b0001 << m_col));
            check_output("q_row_keys", kif.q_row_keys, m_q);
            check_output("hex_code", kif.hex_code, m_hex);
            check_output("key_valid", {3'd0, kif.key_valid}, {3'd0, m_valid});
        end
    end

    task automatic apply_stimulus(input logic [15:0] keys_down, input logic hold_val);
        pressed = keys_down;
        hold_in = hold_val;
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_valid(input logic level, input int budget, input string tag);
        int n;
        n = 0;
        while (kif.key_valid !== level && n < budget) begin
            step();
            n++;
        end
        check_output(tag, {3'd0, kif.key_valid}, {3'd0, level});
    endtask

    task automatic press_and_check(input int r, input int c, input logic [3:0] hex, input string tag);
        apply_stimulus(16'(1) << (r * 4 + c), 1'b0);
        wait_valid(1'b1, 60, {tag, "_lock"});
        check_output({tag, "_hex"}, kif.hex_code, hex);
        check_output({tag, "_cols"}, kif.cols, 4'(4'b0001 << c));
        apply_stimulus(16'd0, 1'b0);
        wait_valid(1'b0, 10, {tag, "_release"});
    endtask

    initial begin
        logic [3:0] prev;
        int         n;
        bit         saw;
        check_count = 0;
        fail_count  = 0;
        check_en    = 0;
        apply_stimulus(16'd0, 1'b0);
        model_reset();
        #1 reset = 1'b0;
        #2;
        check_output("rst_cols", kif.cols, 4'b0001);
        check_output("rst_q_row_keys", kif.q_row_keys, 4'd0);
        check_output("rst_hex_code", kif.hex_code, 4'd0);
        check_output("rst_key_valid", {3'd0, kif.key_valid}, 4'd0);
        @(negedge clk);
        reset = 1'b1;
        check_en = 1;

        // Idle scan: each column stays driven for S+1 cycles
        step();
        prev = kif.cols;
        n = 0;
        while (kif.cols == prev && n < 20) begin step(); n++; end
        prev = kif.cols;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (kif.cols != prev) break;
            n++;
        end
        check_output("scan_period", 4'(n), 4'(S + 1));

        // Key 6 locks on column 2, release advances to column 3
        apply_stimulus(16'(1) << 6, 1'b0);
        wait_valid(1'b1, 60, "k6_lock");
        check_output("k6_hex", kif.hex_code, 4'h6);
        check_output("k6_cols", kif.cols, 4'b0100);
        check_output("k6_q_row_keys", kif.q_row_keys, 4'b0010);
        apply_stimulus(16'd0, 1'b0);
        wait_valid(1'b0, 10, "k6_release");
        check_output("k6_cols_after", kif.cols, 4'b1000);

        // hold keeps the column after the key is gone
        apply_stimulus(16'(1) << 6, 1'b0);
        wait_valid(1'b1, 60, "hold_lock");
        apply_stimulus(16'd0, 1'b1);
        repeat (10) step();
        check_output("hold_cols", kif.cols, 4'b0100);
        check_output("hold_valid", {3'd0, kif.key_valid}, 4'd1);
        apply_stimulus(16'd0, 1'b0);
        step();
        check_output("hold_drop_cols", kif.cols, 4'b1000);
        check_output("hold_drop_valid", {3'd0, kif.key_valid}, 4'd0);

        // Keys 2 and 8 share column 1
        apply_stimulus((16'(1) << 1) | (16'(1) << 9), 1'b0);
`ifdef KEYPAD_MULTI_ROW_REJECT_EN
        saw = 0;
        repeat (3 * 4 * (S + 1)) begin
            step();
            if (kif.key_valid) saw = 1;
        end
        check_output("multi_reject", {3'd0, saw}, 4'd0);
`else
        wait_valid(1'b1, 60, "multi_lock");
        check_output("multi_hex", kif.hex_code, 4'h2);
        check_output("multi_cols", kif.cols, 4'b0010);
        check_output("multi_q_row_keys", kif.q_row_keys, 4'b0101);
`endif
        apply_stimulus(16'd0, 1'b0);
        wait_valid(1'b0, 10, "multi_release");

        press_and_check(3, 1, 4'h0, "k0");
        press_and_check(3, 3, 4'hD, "kD");
        press_and_check(0, 3, 4'hA, "kA");

        // Asynchronous reset in the middle of a lock
        apply_stimulus(16'(1) << 5, 1'b0);
        wait_valid(1'b1, 60, "rst_lock");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("midrst_cols", kif.cols, 4'b0001);
        check_output("midrst_q_row_keys", kif.q_row_keys, 4'd0);
        check_output("midrst_valid", {3'd0, kif.key_valid}, 4'd0);
        check_output("midrst_hex", kif.hex_code, 4'd0);
        apply_stimulus(16'd0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) step();
        check_output("resume_cols", kif.cols, 4'b0001);

        // Random key activity checked cycle by cycle against the model
        for (int t = 0; t < 40; t++) begin
            int kind;
            logic [15:0] k;
            kind = $urandom_range(0, 9);
            k = 16'd0;
            if (kind >= 4) k = 16'(1) << $urandom_range(0, 15);
            if (kind >= 8) k = k | (16'(1) << $urandom_range(0, 15));
            apply_stimulus(k, ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(5, 60)) step();
        end
        apply_stimulus(16'd0, 1'b0);
        repeat (60) step();

        check_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
